// File: rtl/multiplier_sequential_control.sv
// Sequential shift-and-add multiplier: one partial product per clock, W iterations per result,
// registered product with a one-cycle done strobe.
module multiplier_sequential_control #(
    parameter int W = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   alpha,
    input  logic [W-1:0]   beta,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_COUNT = CW'(W - 1);

    logic [1:0]    state;
    logic [W-1:0]  mcand;
    logic [2*W:0]  acc;
    logic [CW-1:0] count;
    logic [W:0]    partial;
    logic [2*W:0]  acc_step;
    logic          capture;

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        partial = acc[2*W:W];
        if (acc[0]) begin
            partial = acc[2*W:W] + {1'b0, mcand};
        end
        acc_step = {1'b0, partial, acc[W-1:1]};
    end

    // Operands are only taken when no iteration is in flight; start during RUN is ignored.
    assign capture = start && (state == S_IDLE || state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            acc     <= '0;
            count   <= '0;
        end else begin
            if (capture) begin
                mcand <= alpha;
                acc   <= {{(W + 1){1'b0}}, beta};
                count <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc   <= acc_step;
                    count <= count + CW'(1);
                    if (count == LAST_COUNT) begin
                        // Carry bit acc_step[2W] is always zero here and never reaches product.
                        product <= acc_step[2*W-1:0];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= start;
                    state <= start ? S_RUN : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
